// File: rtl/multi_interval_timer.sv
// Multi-channel interval timer: NUM_CH prescaled down-counters behind an Avalon-MM slave,
// each with one-shot/continuous mode, snapshot capture and a maskable timeout interrupt.
module multi_interval_timer #(
    parameter int NUM_CH      = 4,
    parameter int WIDTH       = 32,
    parameter int PRE_W       = 16,
    parameter int PERIOD_INIT = 49999,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CH_W+2:0]   address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec
);

    localparam logic [WIDTH-1:0] PERIOD_RST = WIDTH'(PERIOD_INIT);

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD   = 3'd2;
    localparam logic [2:0] REG_SNAP     = 3'd3;
    localparam logic [2:0] REG_PRESCALE = 3'd4;

    logic                  wr_en;
    logic [CH_W-1:0]       ch_sel;
    logic [2:0]            reg_sel;
    logic [NUM_CH-1:0][31:0] rd_word;
    logic [31:0]           rd_mux;

    assign wr_en   = chipselect & ~write_n;
    assign ch_sel  = address[CH_W+2:3];
    assign reg_sel = address[2:0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [WIDTH-1:0] cnt_reg, cnt_next;
            logic [WIDTH-1:0] period_reg, period_next;
            logic [WIDTH-1:0] snap_reg, snap_next;
            logic [PRE_W-1:0] pre_reg, pre_next;
            logic [PRE_W-1:0] presc_reg, presc_next;
            logic             ito_reg, ito_next;
            logic             cont_reg, cont_next;
            logic             to_reg, to_next;
            logic             run_reg, run_next;
            logic             reload_reg, reload_next;
            logic             irq_reg;
            logic             sel, w_status, w_ctrl, w_period, w_snap, w_pre;
            logic             start, stop, tick;

            assign sel      = wr_en && (ch_sel == CH_W'(gi));
            assign w_status = sel && (reg_sel == REG_STATUS);
            assign w_ctrl   = sel && (reg_sel == REG_CONTROL);
            assign w_period = sel && (reg_sel == REG_PERIOD);
            assign w_snap   = sel && (reg_sel == REG_SNAP);
            assign w_pre    = sel && (reg_sel == REG_PRESCALE);
            assign start    = w_ctrl && writedata[2];
            assign stop     = w_ctrl && writedata[3];
            assign tick     = run_reg && (presc_reg == pre_reg);

            always_comb begin
                cnt_next    = cnt_reg;
                period_next = period_reg;
                snap_next   = snap_reg;
                pre_next    = pre_reg;
                presc_next  = presc_reg;
                ito_next    = ito_reg;
                cont_next   = cont_reg;
                to_next     = to_reg;
                run_next    = run_reg;
                reload_next = w_period;

                if (w_ctrl) begin
                    ito_next  = writedata[0];
                    cont_next = writedata[1];
                end
                if (w_period)
                    period_next = writedata[WIDTH-1:0];
                if (w_snap)
                    snap_next = cnt_reg;
                if (w_status)
                    to_next = 1'b0;

                // A period write takes effect one cycle later and parks the channel.
                if (reload_reg) begin
                    cnt_next   = period_reg;
                    presc_next = '0;
                    run_next   = 1'b0;
                end else if (run_reg) begin
                    presc_next = tick ? '0 : presc_reg + PRE_W'(1);
                    if (tick) begin
                        if (cnt_reg != '0) begin
                            cnt_next = cnt_reg - WIDTH'(1);
                        end else begin
                            cnt_next = period_reg;
                            to_next  = 1'b1;
                            if (!cont_reg)
                                run_next = 1'b0;
                        end
                    end
                end

                if (stop)
                    run_next = 1'b0;
                if (w_pre) begin
                    pre_next   = writedata[PRE_W-1:0];
                    presc_next = '0;
                end
                // START overrides STOP; restarting from idle begins a fresh prescale interval.
                if (start) begin
                    run_next = 1'b1;
                    if (!run_reg)
                        presc_next = '0;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg    <= PERIOD_RST;
                    period_reg <= PERIOD_RST;
                    snap_reg   <= '0;
                    pre_reg    <= '0;
                    presc_reg  <= '0;
                    ito_reg    <= 1'b0;
                    cont_reg   <= 1'b0;
                    to_reg     <= 1'b0;
                    run_reg    <= 1'b0;
                    reload_reg <= 1'b0;
                    irq_reg    <= 1'b0;
                end else begin
                    cnt_reg    <= cnt_next;
                    period_reg <= period_next;
                    snap_reg   <= snap_next;
                    pre_reg    <= pre_next;
                    presc_reg  <= presc_next;
                    ito_reg    <= ito_next;
                    cont_reg   <= cont_next;
                    to_reg     <= to_next;
                    run_reg    <= run_next;
                    reload_reg <= reload_next;
                    irq_reg    <= to_next & ito_next;
                end
            end

            always_comb begin
                rd_word[gi] = '0;
                case (reg_sel)
                    REG_STATUS:   rd_word[gi] = {30'd0, run_reg, to_reg};
                    REG_CONTROL:  rd_word[gi] = {30'd0, cont_reg, ito_reg};
                    REG_PERIOD:   rd_word[gi] = 32'(period_reg);
                    REG_SNAP:     rd_word[gi] = 32'(snap_reg);
                    REG_PRESCALE: rd_word[gi] = 32'(pre_reg);
                    default:      rd_word[gi] = '0;
                endcase
            end

            assign irq_vec[gi] = irq_reg;
        end
    endgenerate

    // Channel indices beyond NUM_CH match nothing and read as zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == CH_W'(i))
                rd_mux = rd_word[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            readdata <= '0;
        else
            readdata <= rd_mux;
    end

    assign irq = |irq_vec;

endmodule

// File: tb/tb_multi_interval_timer.sv
// Directed bench for multi_interval_timer: bus tasks, hand-computed expectations,
// one printed line per checked transaction.
module tb_multi_interval_timer;

    localparam int NUM_CH = 3;
    localparam int WIDTH  = 16;
    localparam int PRE_W  = 8;
    localparam int AW     = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [AW-1:0]     address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              irq;
    logic [NUM_CH-1:0] irq_vec;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multi_interval_timer #(
        .NUM_CH(NUM_CH),
        .WIDTH(WIDTH),
        .PRE_W(PRE_W),
        .PERIOD_INIT(49999)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .irq(irq),
        .irq_vec(irq_vec)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    function automatic logic [AW-1:0] reg_addr(input int ch, input int r);
        return AW'((ch << 3) | (r & 7));
    endfunction

    // Tasks start and end just after a falling edge; the write lands on the rising edge between.
    task automatic bus_write(input int ch, input int r, input logic [31:0] data);
        address    = reg_addr(ch, r);
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_check(input int ch, input int r, input logic [31:0] exp, input string tag);
        address    = reg_addr(ch, r);
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
        check_eq(tag, readdata, exp);
    endtask

    // Counts falling edges until irq_vec[idx] is seen high; the first sample is cycle 1.
    task automatic wait_irq(input int idx, output int cyc);
        cyc = 1;
        while (!irq_vec[idx] && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_irq", 32'(irq), 32'd0);
        check_eq("rst_irq_vec", 32'(irq_vec), 32'd0);
        check_eq("rst_readdata", readdata, 32'd0);
        reset = 1'b0;
        rd_check(0, 2, 32'd49999, "rst_period0");
        rd_check(0, 0, 32'd0, "rst_status0");

        // One-shot on ch1: PERIOD=4, PRESCALE=0, ITO|START.
        bus_write(1, 2, 32'd4);
        bus_write(1, 4, 32'd0);
        bus_write(1, 1, 32'h5);
        wait_irq(1, c);
        check_eq("os_irq_latency", 32'(c), 32'd6);
        check_eq("os_irq_or", 32'(irq), 32'd1);
        rd_check(1, 0, 32'h1, "os_status");
        bus_write(1, 3, 32'd0);
        rd_check(1, 3, 32'd4, "os_snap_hold");
        bus_write(1, 0, 32'd0);
        check_eq("os_irq_clear", 32'(irq_vec), 32'd0);

        // Continuous on ch0: PERIOD=2, PRESCALE=3 -> 12-cycle period.
        bus_write(0, 2, 32'd2);
        bus_write(0, 4, 32'd3);
        bus_write(0, 1, 32'h7);
        wait_irq(0, c);
        check_eq("cont_first", 32'(c), 32'd13);
        for (int p = 1; p < 5; p++) begin
            bus_write(0, 0, 32'd0);
            wait_irq(0, c);
            check_eq($sformatf("cont_period%0d", p), 32'(c), 32'd12);
        end
        bus_write(0, 0, 32'd0);
        repeat (4) @(negedge clk);
        bus_write(0, 3, 32'd0);
        rd_check(0, 3, 32'd1, "cont_snap_mid");
        @(negedge clk);
        bus_write(0, 3, 32'd0);
        rd_check(0, 3, 32'd0, "cont_snap_zero");
        bus_write(0, 1, 32'h8);
        rd_check(0, 0, 32'h0, "cont_stopped");

        // Collisions on ch2: PERIOD=0 means every tick is a zero tick.
        bus_write(2, 2, 32'd0);
        bus_write(2, 4, 32'd0);
        bus_write(2, 1, 32'h6);
        bus_write(2, 0, 32'd0);
        rd_check(2, 0, 32'h3, "col_status_vs_tick");
        bus_write(2, 1, 32'h8);
        rd_check(2, 0, 32'h1, "col_stop_vs_tick");
        bus_write(2, 0, 32'd0);
        rd_check(2, 0, 32'h0, "col_to_cleared");
        bus_write(2, 1, 32'hC);
        rd_check(2, 0, 32'h2, "col_start_wins");
        bus_write(2, 1, 32'h8);
        bus_write(2, 0, 32'd0);

        // Period reload mid-count on ch2.
        bus_write(2, 2, 32'd20);
        @(negedge clk);
        bus_write(2, 1, 32'h4);
        repeat (3) @(negedge clk);
        bus_write(2, 2, 32'd10);
        @(negedge clk);
        bus_write(2, 3, 32'd0);
        rd_check(2, 3, 32'd10, "reload_counter");
        rd_check(2, 0, 32'h0, "reload_run_clear");
        bus_write(2, 1, 32'h5);
        wait_irq(2, c);
        check_eq("reload_timeout", 32'(c), 32'd12);
        bus_write(2, 0, 32'd0);

        // Address decode: nonexistent channel and reserved register.
        bus_write(3, 2, 32'd7);
        rd_check(3, 2, 32'd0, "ch3_period_rd");
        rd_check(3, 0, 32'd0, "ch3_status_rd");
        bus_write(0, 6, 32'hFFFF_FFFF);
        rd_check(0, 6, 32'd0, "reg6_rd");
        rd_check(0, 2, 32'd2, "ch0_period_kept");
        rd_check(0, 1, 32'd0, "ch0_control_kept");
        check_eq("decode_irq_vec", 32'(irq_vec), 32'd0);

        // Reset mid-count with an interrupt pending.
        bus_write(0, 1, 32'h7);
        wait_irq(0, c);
        check_eq("pre_rst_irq", 32'(irq), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_irq", 32'(irq), 32'd0);
        check_eq("mid_rst_irq_vec", 32'(irq_vec), 32'd0);
        check_eq("mid_rst_readdata", readdata, 32'd0);
        reset = 1'b0;
        rd_check(0, 2, 32'd49999, "mid_rst_period0");
        rd_check(0, 0, 32'd0, "mid_rst_status0");
        rd_check(0, 1, 32'd0, "mid_rst_control0");
        rd_check(0, 4, 32'd0, "mid_rst_prescale0");
        rd_check(0, 3, 32'd0, "mid_rst_snap0");
        bus_write(0, 3, 32'd0);
        rd_check(0, 3, 32'd49999, "mid_rst_counter0");
        rd_check(2, 2, 32'd49999, "mid_rst_period2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
